snake_ring_engine: RTL and testbench

Parametrised snake-body engine for the GreedySnake BSRAM designs. It stores the body as a ring buffer of packed {x,y} positions in one Gowin DPB port and supports three commands: reset, step and read-out. On each step it computes the next head, checks walls and self-collision with a full body scan, and handles food/growth in one transaction. It sits between the game-control FSM (command side) and channel A of the DPB; the display logic reads channel B.

---
 rtl/snake_ring_engine_pkg.sv | 28 ++
 rtl/snake_ring_engine_if.sv | 30 +++
 rtl/snake_ring_engine_next_pos.sv | 46 ++++
 rtl/snake_ring_engine.sv | 215 +++++++++++++++++++++
 tb/tb_snake_ring_engine.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/snake_ring_engine_pkg.sv
// Shared codes for the snake ring engine: command modes, directions and FSM states.
package snake_pkg;

  localparam logic [1:0] MODE_RESET = 2'd0;
  localparam logic [1:0] MODE_STEP  = 2'd1;
  localparam logic [1:0] MODE_READ  = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  localparam logic [1:0] FORWARD_X_UP   = 2'b00;
  localparam logic [1:0] FORWARD_X_DOWN = 2'b01;
  localparam logic [1:0] FORWARD_Y_UP   = 2'b10;
  localparam logic [1:0] FORWARD_Y_DOWN = 2'b11;

  typedef logic [2:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE    = 3'd0;
  localparam fsm_state_t ST_INIT_WR = 3'd1;
  localparam fsm_state_t ST_CALC    = 3'd2;
  localparam fsm_state_t ST_SCAN    = 3'd3;
  localparam fsm_state_t ST_DRAIN   = 3'd4;
  localparam fsm_state_t ST_WRITE   = 3'd5;
  localparam fsm_state_t ST_DONE    = 3'd6;

  // Direction pairs differ only in the LSB.
  function automatic logic [1:0] opposite(input logic [1:0] f);
    return f ^ 2'b01;
  endfunction

endpackage

// File: rtl/snake_ring_engine_if.sv
// Command/status bundle between the game-control FSM (master) and the snake engine (slave).
interface snake_ring_engine_if #(
  parameter int POS_W = 8,
  parameter int PTR_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [1:0]       forward;
  logic [POS_W-1:0] food_pos;
  logic [PTR_W-1:0] rd_index;
  logic             done;
  logic             ate;
  logic             hit_wall;
  logic             hit_self;
  logic             dead;
  logic [POS_W-1:0] rd_pos;
  logic [POS_W-1:0] head_pos;
  logic [PTR_W:0]   length;

  modport master (
    output cmd_valid, cmd_mode, forward, food_pos, rd_index,
    input  cmd_ready, done, ate, hit_wall, hit_self, dead, rd_pos, head_pos, length
  );

  modport slave (
    input  cmd_valid, cmd_mode, forward, food_pos, rd_index,
    output cmd_ready, done, ate, hit_wall, hit_self, dead, rd_pos, head_pos, length
  );
endinterface

// File: rtl/snake_ring_engine_next_pos.sv
// Combinational next-head calculation with torus wrap or wall detection.
module snake_next_pos
  import snake_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int GRID_X  = 16,
  parameter int GRID_Y  = 16,
  parameter int WRAP_EN = 0
) (
  input  logic [2*COORD_W-1:0] head,
  input  logic [1:0]           dir,
  output logic [2*COORD_W-1:0] next,
  output logic                 hit_wall
);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_X - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_Y - 1);
  localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);
  localparam logic               WALL  = (WRAP_EN == 0);

  logic [COORD_W-1:0] x, y, nx, ny;

  assign x = head[2*COORD_W-1:COORD_W];
  assign y = head[COORD_W-1:0];

  always_comb begin
    nx       = x;
    ny       = y;
    hit_wall = 1'b0;
    case (dir)
      FORWARD_X_UP:
        if (x == X_MAX) begin nx = '0; hit_wall = WALL; end
        else nx = x + C_ONE;
      FORWARD_X_DOWN:
        if (x == '0) begin nx = X_MAX; hit_wall = WALL; end
        else nx = x - C_ONE;
      FORWARD_Y_UP:
        if (y == Y_MAX) begin ny = '0; hit_wall = WALL; end
        else ny = y + C_ONE;
      default:
        if (y == '0) begin ny = Y_MAX; hit_wall = WALL; end
        else ny = y - C_ONE;
    endcase
  end

  assign next = {nx, ny};
endmodule

// File: rtl/snake_ring_engine.sv
// Snake body engine: ring buffer of packed {x,y} positions on DPB channel A with
// reset, step (move / grow / collide) and indexed read-out commands.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// INIT_WR | writing the initial body, one word per cycle
// CALC    | next head, wall check, grow decision
// SCAN    | one body read issued per cycle
// DRAIN   | waiting RD_LAT cycles for the last read data
// WRITE   | commit: new head written or RESET pointers loaded
// DONE    | done pulse, back to IDLE
module snake_ring_engine
  import snake_pkg::*;
#(
  parameter int COORD_W   = 4,
  parameter int GRID_X    = 16,
  parameter int GRID_Y    = 16,
  parameter int MAX_LEN   = 256,
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0,
  parameter int RAM_DW    = 8,
  parameter int RD_LAT    = 1,
  parameter int WRAP_EN   = 0,
  parameter int INIT_LEN  = 3,
  parameter int INIT_X    = 8,
  parameter int INIT_Y    = 8,
  localparam int POS_W    = 2 * COORD_W,
  localparam int PTR_W    = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  snake_ring_engine_if.slave cmd,
  output logic               ram_ce,
  output logic               ram_oce,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [RAM_DW-1:0]  ram_wdata,
  input  logic [RAM_DW-1:0]  ram_rdata
);
  localparam int LEN_W = PTR_W + 1;
  localparam logic [LEN_W-1:0]   LEN_MAX    = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_ONE    = LEN_W'(1);
  localparam logic [LEN_W-1:0]   INIT_LAST  = LEN_W'(INIT_LEN - 1);
  localparam logic [LEN_W-1:0]   INIT_LEN_L = LEN_W'(INIT_LEN);
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0]   INIT_HEAD  = PTR_W'(INIT_LEN - 1);
  localparam logic [COORD_W-1:0] INIT_X0    = COORD_W'(INIT_X - INIT_LEN + 1);
  localparam logic [COORD_W-1:0] INIT_XL    = COORD_W'(INIT_X);
  localparam logic [COORD_W-1:0] INIT_YL    = COORD_W'(INIT_Y);
  localparam logic [1:0]         DRAIN_LAST = 2'(RD_LAT - 1);

  fsm_state_t       state;
  logic [1:0]       mode_q, dir_q, last_dir, dir_f, drain_cnt;
  logic [POS_W-1:0] food_q, next_q, head_pos_q, rd_pos_q, next_c, wpos;
  logic [PTR_W-1:0] idx_q, head_ptr, tail_ptr, ptr_sel;
  logic [LEN_W-1:0] length_q, scan_n, scan_n_c, cnt;
  logic             grow_q, dead_q, ate_q, wall_q, self_q;
  logic             wall_c, food_c, grow_c, read_ok, vin;
  logic [RD_LAT-1:0] vp_q;
  logic [COORD_W-1:0] init_x;

  snake_next_pos #(
    .COORD_W (COORD_W),
    .GRID_X  (GRID_X),
    .GRID_Y  (GRID_Y),
    .WRAP_EN (WRAP_EN)
  ) u_next_pos (
    .head     (head_pos_q),
    .dir      (dir_q),
    .next     (next_c),
    .hit_wall (wall_c)
  );

  assign dir_f    = (cmd.forward == opposite(last_dir)) ? last_dir : cmd.forward;
  assign food_c   = (next_c == food_q) && !wall_c;
  assign grow_c   = food_c && (length_q < LEN_MAX);
  assign scan_n_c = grow_c ? length_q : length_q - LEN_ONE;
  assign read_ok  = ({1'b0, idx_q} < length_q);
  assign vin      = (state == ST_SCAN) && ((mode_q == MODE_STEP) || read_ok);
  assign init_x   = INIT_X0 + COORD_W'(cnt);

  always_comb begin
    ptr_sel = '0;
    case (state)
      ST_INIT_WR: ptr_sel = cnt[PTR_W-1:0];
      ST_SCAN:    ptr_sel = head_ptr - ((mode_q == MODE_READ) ? idx_q : cnt[PTR_W-1:0]);
      ST_WRITE:   ptr_sel = head_ptr + PTR_ONE;
      default:    ptr_sel = '0;
    endcase
  end

  assign wpos      = (state == ST_INIT_WR) ? {init_x, INIT_YL} : next_q;
  assign ram_ce    = 1'b1;
  assign ram_oce   = 1'b1;
  assign ram_we    = (state == ST_INIT_WR) ||
                     ((state == ST_WRITE) && (mode_q == MODE_STEP) && !wall_q && !self_q);
  assign ram_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(ptr_sel);
  assign ram_wdata = RAM_DW'(wpos);

  // Valid pipe lines returned read data up with the address issued RD_LAT cycles earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vp_q <= '0;
    else        vp_q <= RD_LAT'({vp_q, vin});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      dir_q      <= '0;
      last_dir   <= FORWARD_X_UP;
      food_q     <= '0;
      idx_q      <= '0;
      next_q     <= '0;
      head_pos_q <= '0;
      rd_pos_q   <= '0;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      length_q   <= '0;
      scan_n     <= '0;
      cnt        <= '0;
      drain_cnt  <= '0;
      grow_q     <= 1'b0;
      dead_q     <= 1'b0;
      ate_q      <= 1'b0;
      wall_q     <= 1'b0;
      self_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cmd.cmd_valid) begin
          mode_q <= cmd.cmd_mode;
          dir_q  <= dir_f;
          food_q <= cmd.food_pos;
          idx_q  <= cmd.rd_index;
          cnt    <= '0;
          case (cmd.cmd_mode)
            MODE_RESET: state <= ST_INIT_WR;
            MODE_STEP:  state <= ST_CALC;
            MODE_READ:  begin state <= ST_SCAN; rd_pos_q <= '0; end
            default:    state <= ST_DONE;
          endcase
        end
        ST_INIT_WR: begin
          cnt <= cnt + LEN_ONE;
          if (cnt == INIT_LAST) state <= ST_WRITE;
        end
        ST_CALC: begin
          if (dead_q || (length_q == '0)) begin
            state <= ST_DONE;
          end else begin
            ate_q     <= food_c;
            wall_q    <= wall_c;
            self_q    <= 1'b0;
            next_q    <= next_c;
            grow_q    <= grow_c;
            scan_n    <= scan_n_c;
            drain_cnt <= '0;
            if (wall_c)                 state <= ST_WRITE;
            else if (scan_n_c == '0)    state <= ST_DRAIN;
            else                        state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          cnt       <= cnt + LEN_ONE;
          drain_cnt <= '0;
          if ((mode_q == MODE_READ) || (cnt == scan_n - LEN_ONE)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == DRAIN_LAST) state <= (mode_q == MODE_READ) ? ST_DONE : ST_WRITE;
        end
        ST_WRITE: begin
          state <= ST_DONE;
          if (mode_q == MODE_RESET) begin
            head_ptr   <= INIT_HEAD;
            tail_ptr   <= '0;
            length_q   <= INIT_LEN_L;
            last_dir   <= FORWARD_X_UP;
            head_pos_q <= {INIT_XL, INIT_YL};
            dead_q     <= 1'b0;
            ate_q      <= 1'b0;
            wall_q     <= 1'b0;
            self_q     <= 1'b0;
          end else if (wall_q || self_q) begin
            dead_q <= 1'b1;
          end else begin
            head_ptr   <= head_ptr + PTR_ONE;
            head_pos_q <= next_q;
            last_dir   <= dir_q;
            if (grow_q) length_q <= length_q + LEN_ONE;
            else        tail_ptr <= tail_ptr + PTR_ONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Stored words carry zero MSBs, so a full-width compare is exact.
      if (vp_q[RD_LAT-1]) begin
        if ((mode_q == MODE_STEP) && (ram_rdata == RAM_DW'(next_q))) self_q <= 1'b1;
        if (mode_q == MODE_READ) rd_pos_q <= ram_rdata[POS_W-1:0];
      end
    end
  end

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign cmd.done      = (state == ST_DONE);
  assign cmd.ate       = ate_q;
  assign cmd.hit_wall  = wall_q;
  assign cmd.hit_self  = self_q;
  assign cmd.dead      = dead_q;
  assign cmd.rd_pos    = rd_pos_q;
  assign cmd.head_pos  = head_pos_q;
  assign cmd.length    = length_q;
endmodule

// File: tb/tb_snake_ring_engine.sv
// Directed bench: unit 0 is the default build (RD_LAT=1, walls), unit 1 uses RD_LAT=2 with wrap.
module tb_snake_ring_engine;
  import snake_pkg::*;

  logic clk = 1'b0;
  logic rst_n0, rst_n1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  snake_ring_engine_if #(.POS_W(8), .PTR_W(8)) c0 ();
  snake_ring_engine_if #(.POS_W(8), .PTR_W(8)) c1 ();

  logic        ce0, oce0, we0, ce1, oce1, we1;
  logic [10:0] addr0, addr1;
  logic [7:0]  wd0, wd1, rd0, rd1a, rd1b;
  logic [7:0]  mem0 [0:2047];
  logic [7:0]  mem1 [0:2047];

  snake_ring_engine dut0 (
    .clk(clk), .rst_n(rst_n0), .cmd(c0),
    .ram_ce(ce0), .ram_oce(oce0), .ram_we(we0),
    .ram_addr(addr0), .ram_wdata(wd0), .ram_rdata(rd0)
  );

  snake_ring_engine #(.RD_LAT(2), .WRAP_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .cmd(c1),
    .ram_ce(ce1), .ram_oce(oce1), .ram_we(we1),
    .ram_addr(addr1), .ram_wdata(wd1), .ram_rdata(rd1b)
  );

  // Synchronous RAM models; unit 1 has the extra output register.
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= wd0;
    rd0 <= mem0[addr0];
    if (we1) mem1[addr1] <= wd1;
    rd1a <= mem1[addr1];
    rd1b <= rd1a;
  end

  // Issue one command, return cycles from acceptance to done (-1 on timeout) and writes seen.
  task automatic run_cmd(input int u, input logic [1:0] mode, input logic [1:0] fwd,
                         input logic [7:0] food, input logic [7:0] idx,
                         output int lat, output int nwr);
    logic d, w;
    @(negedge clk);
    if (u == 0) begin
      c0.cmd_valid = 1'b1; c0.cmd_mode = mode; c0.forward = fwd; c0.food_pos = food; c0.rd_index = idx;
    end else begin
      c1.cmd_valid = 1'b1; c1.cmd_mode = mode; c1.forward = fwd; c1.food_pos = food; c1.rd_index = idx;
    end
    @(posedge clk);
    #1;
    if (u == 0) c0.cmd_valid = 1'b0; else c1.cmd_valid = 1'b0;
    lat = -1;
    nwr = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      d = (u == 0) ? c0.done : c1.done;
      w = (u == 0) ? we0 : we1;
      if (w) nwr++;
      if (d) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    int lat, nwr;
    checks++; if (c0.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", c0.cmd_ready); end
    checks++; if (c0.length !== 9'd0) begin errors++; $display("FAIL rst_length got %0d exp 0", c0.length); end
    checks++; if (c0.head_pos !== 8'h00) begin errors++; $display("FAIL rst_head got %0h exp 0", c0.head_pos); end
    checks++; if ({c0.done, c0.dead, we0} !== 3'b000) begin errors++; $display("FAIL rst_done_dead_we got %0b exp 000", {c0.done, c0.dead, we0}); end
    checks++; if ({ce0, oce0} !== 2'b11) begin errors++; $display("FAIL rst_ce_oce got %0b exp 11", {ce0, oce0}); end
    run_cmd(0, MODE_RESET, 2'b00, 8'h00, 8'h00, lat, nwr);
    checks++; if (lat !== 5) begin errors++; $display("FAIL reset_lat got %0d exp 5", lat); end
    checks++; if (nwr !== 3) begin errors++; $display("FAIL reset_nwr got %0d exp 3", nwr); end
    checks++; if ({mem0[0], mem0[1], mem0[2]} !== 24'h687888) begin errors++; $display("FAIL reset_mem got %0h exp 687888", {mem0[0], mem0[1], mem0[2]}); end
    checks++; if (c0.length !== 9'd3) begin errors++; $display("FAIL reset_length got %0d exp 3", c0.length); end
    checks++; if (c0.head_pos !== 8'h88) begin errors++; $display("FAIL reset_head got %0h exp 88", c0.head_pos); end
  endtask

  task automatic test_step();
    int lat, nwr;
    run_cmd(0, MODE_STEP, FORWARD_X_UP, 8'hF0, 8'h00, lat, nwr);
    checks++; if (lat !== 6) begin errors++; $display("FAIL step_lat got %0d exp 6", lat); end
    checks++; if (nwr !== 1) begin errors++; $display("FAIL step_nwr got %0d exp 1", nwr); end
    checks++; if (c0.head_pos !== 8'h98) begin errors++; $display("FAIL step_head got %0h exp 98", c0.head_pos); end
    checks++; if (mem0[3] !== 8'h98) begin errors++; $display("FAIL step_mem3 got %0h exp 98", mem0[3]); end
    checks++; if (dut0.tail_ptr !== 8'd1) begin errors++; $display("FAIL step_tail got %0d exp 1", dut0.tail_ptr); end
    checks++; if (c0.length !== 9'd3) begin errors++; $display("FAIL step_length got %0d exp 3", c0.length); end
    checks++; if ({c0.ate, c0.hit_wall, c0.hit_self} !== 3'b000) begin errors++; $display("FAIL step_flags got %0b exp 000", {c0.ate, c0.hit_wall, c0.hit_self}); end
  endtask

  task automatic test_eat();
    int lat, nwr;
    run_cmd(0, MODE_STEP, FORWARD_X_UP, 8'hA8, 8'h00, lat, nwr);
    checks++; if (lat !== 7) begin errors++; $display("FAIL eat_lat got %0d exp 7", lat); end
    checks++; if (c0.ate !== 1'b1) begin errors++; $display("FAIL eat_ate got %0b exp 1", c0.ate); end
    checks++; if (c0.length !== 9'd4) begin errors++; $display("FAIL eat_length got %0d exp 4", c0.length); end
    checks++; if (dut0.tail_ptr !== 8'd1) begin errors++; $display("FAIL eat_tail got %0d exp 1", dut0.tail_ptr); end
    checks++; if (mem0[4] !== 8'hA8) begin errors++; $display("FAIL eat_mem4 got %0h exp a8", mem0[4]); end
  endtask

  task automatic test_reversal();
    int lat, nwr;
    run_cmd(0, MODE_STEP, FORWARD_X_DOWN, 8'hF0, 8'h00, lat, nwr);
    checks++; if (lat !== 7) begin errors++; $display("FAIL rev_lat got %0d exp 7", lat); end
    checks++; if (c0.head_pos !== 8'hB8) begin errors++; $display("FAIL rev_head got %0h exp b8", c0.head_pos); end
    checks++; if ({c0.hit_self, c0.dead, c0.ate} !== 3'b000) begin errors++; $display("FAIL rev_flags got %0b exp 000", {c0.hit_self, c0.dead, c0.ate}); end
    checks++; if (dut0.tail_ptr !== 8'd2) begin errors++; $display("FAIL rev_tail got %0d exp 2", dut0.tail_ptr); end
  endtask

  task automatic test_read();
    int lat, nwr;
    run_cmd(0, MODE_READ, 2'b00, 8'h00, 8'd0, lat, nwr);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read0_lat got %0d exp 3", lat); end
    checks++; if (c0.rd_pos !== 8'hB8) begin errors++; $display("FAIL read0_pos got %0h exp b8", c0.rd_pos); end
    run_cmd(0, MODE_READ, 2'b00, 8'h00, 8'd3, lat, nwr);
    checks++; if (c0.rd_pos !== 8'h88) begin errors++; $display("FAIL read3_pos got %0h exp 88", c0.rd_pos); end
    run_cmd(0, MODE_READ, 2'b00, 8'h00, 8'd4, lat, nwr);
    checks++; if (c0.rd_pos !== 8'h00) begin errors++; $display("FAIL read_oob_pos got %0h exp 0", c0.rd_pos); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL read_oob_nwr got %0d exp 0", nwr); end
  endtask

  task automatic test_self_hit();
    int lat, nwr;
    run_cmd(0, MODE_STEP, FORWARD_Y_UP, 8'hB9, 8'h00, lat, nwr);
    checks++; if (lat !== 8) begin errors++; $display("FAIL grow5_lat got %0d exp 8", lat); end
    checks++; if (c0.length !== 9'd5) begin errors++; $display("FAIL grow5_length got %0d exp 5", c0.length); end
    run_cmd(0, MODE_STEP, FORWARD_X_DOWN, 8'hF0, 8'h00, lat, nwr);
    checks++; if (c0.head_pos !== 8'hA9) begin errors++; $display("FAIL loop_head got %0h exp a9", c0.head_pos); end
    run_cmd(0, MODE_STEP, FORWARD_Y_DOWN, 8'hF0, 8'h00, lat, nwr);
    checks++; if (lat !== 8) begin errors++; $display("FAIL self_lat got %0d exp 8", lat); end
    checks++; if ({c0.hit_self, c0.dead, c0.hit_wall} !== 3'b110) begin errors++; $display("FAIL self_flags got %0b exp 110", {c0.hit_self, c0.dead, c0.hit_wall}); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL self_nwr got %0d exp 0", nwr); end
    checks++; if (c0.head_pos !== 8'hA9 || c0.length !== 9'd5) begin errors++; $display("FAIL self_state got %0h/%0d exp a9/5", c0.head_pos, c0.length); end
    run_cmd(0, MODE_STEP, FORWARD_X_UP, 8'hF0, 8'h00, lat, nwr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dead_lat got %0d exp 2", lat); end
    checks++; if (c0.hit_self !== 1'b1 || nwr !== 0) begin errors++; $display("FAIL dead_noop got %0b/%0d exp 1/0", c0.hit_self, nwr); end
    run_cmd(0, MODE_RSVD, 2'b00, 8'h00, 8'h00, lat, nwr);
    checks++; if (lat < 1 || nwr !== 0) begin errors++; $display("FAIL rsvd got %0d/%0d exp done/0", lat, nwr); end
    run_cmd(0, MODE_RESET, 2'b00, 8'h00, 8'h00, lat, nwr);
    checks++; if ({c0.dead, c0.hit_self} !== 2'b00 || c0.length !== 9'd3) begin errors++; $display("FAIL reset_clear got %0b/%0d exp 00/3", {c0.dead, c0.hit_self}, c0.length); end
  endtask

  task automatic test_wall();
    int lat, nwr, bad;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      run_cmd(0, MODE_STEP, FORWARD_X_UP, 8'hF0, 8'h00, lat, nwr);
      if (lat != 6) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL walk_lat got %0d bad exp 0", bad); end
    checks++; if (c0.head_pos !== 8'hF8) begin errors++; $display("FAIL walk_head got %0h exp f8", c0.head_pos); end
    run_cmd(0, MODE_STEP, FORWARD_X_UP, 8'hF0, 8'h00, lat, nwr);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wall_lat got %0d exp 3", lat); end
    checks++; if ({c0.hit_wall, c0.dead, c0.hit_self, c0.ate} !== 4'b1100) begin errors++; $display("FAIL wall_flags got %0b exp 1100", {c0.hit_wall, c0.dead, c0.hit_self, c0.ate}); end
    checks++; if (nwr !== 0 || c0.head_pos !== 8'hF8) begin errors++; $display("FAIL wall_state got %0d/%0h exp 0/f8", nwr, c0.head_pos); end
  endtask

  task automatic test_tail_vacate();
    int lat, nwr;
    run_cmd(0, MODE_RESET, 2'b00, 8'h00, 8'h00, lat, nwr);
    run_cmd(0, MODE_STEP, FORWARD_X_UP, 8'h98, 8'h00, lat, nwr);
    run_cmd(0, MODE_STEP, FORWARD_Y_UP, 8'hF0, 8'h00, lat, nwr);
    run_cmd(0, MODE_STEP, FORWARD_X_DOWN, 8'hF0, 8'h00, lat, nwr);
    run_cmd(0, MODE_STEP, FORWARD_Y_DOWN, 8'hF0, 8'h00, lat, nwr);
    checks++; if (lat !== 7) begin errors++; $display("FAIL tail_lat got %0d exp 7", lat); end
    checks++; if ({c0.hit_self, c0.dead} !== 2'b00) begin errors++; $display("FAIL tail_flags got %0b exp 00", {c0.hit_self, c0.dead}); end
    checks++; if (c0.head_pos !== 8'h88 || c0.length !== 9'd4) begin errors++; $display("FAIL tail_state got %0h/%0d exp 88/4", c0.head_pos, c0.length); end
  endtask

  task automatic test_lat2_wrap();
    int lat, nwr, bad;
    run_cmd(1, MODE_RESET, 2'b00, 8'h00, 8'h00, lat, nwr);
    checks++; if (lat !== 5 || mem1[0] !== 8'h68) begin errors++; $display("FAIL u1_reset got %0d/%0h exp 5/68", lat, mem1[0]); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      run_cmd(1, MODE_STEP, FORWARD_X_UP, 8'hF0, 8'h00, lat, nwr);
      if (lat != 7) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL u1_step_lat got %0d bad exp 0", bad); end
    checks++; if (c1.head_pos !== 8'h08) begin errors++; $display("FAIL u1_wrap_head got %0h exp 08", c1.head_pos); end
    checks++; if ({c1.hit_wall, c1.dead} !== 2'b00) begin errors++; $display("FAIL u1_wrap_flags got %0b exp 00", {c1.hit_wall, c1.dead}); end
    run_cmd(1, MODE_READ, 2'b00, 8'h00, 8'd1, lat, nwr);
    checks++; if (lat !== 4) begin errors++; $display("FAIL u1_read_lat got %0d exp 4", lat); end
    checks++; if (c1.rd_pos !== 8'hF8) begin errors++; $display("FAIL u1_read_pos got %0h exp f8", c1.rd_pos); end
  endtask

  task automatic test_abort();
    int lat, nwr, seen;
    @(negedge clk);
    c1.cmd_valid = 1'b1; c1.cmd_mode = MODE_STEP; c1.forward = FORWARD_X_UP; c1.food_pos = 8'hF0;
    @(posedge clk);
    #1 c1.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dut1.state !== ST_SCAN) begin errors++; $display("FAIL abort_in_scan got %0d exp %0d", dut1.state, ST_SCAN); end
    rst_n1 = 1'b0;
    #1;
    checks++; if (c1.cmd_ready !== 1'b1 || c1.length !== 9'd0) begin errors++; $display("FAIL abort_state got %0b/%0d exp 1/0", c1.cmd_ready, c1.length); end
    checks++; if ({we1, c1.done} !== 2'b00) begin errors++; $display("FAIL abort_we_done got %0b exp 00", {we1, c1.done}); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (c1.done) seen++; end
    rst_n1 = 1'b1;
    repeat (8) begin @(negedge clk); if (c1.done) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", seen); end
    run_cmd(1, MODE_STEP, FORWARD_X_UP, 8'hF0, 8'h00, lat, nwr);
    checks++; if (lat !== 2 || nwr !== 0) begin errors++; $display("FAIL len0_step got %0d/%0d exp 2/0", lat, nwr); end
    run_cmd(1, MODE_RESET, 2'b00, 8'h00, 8'h00, lat, nwr);
    checks++; if (lat !== 5 || c1.length !== 9'd3) begin errors++; $display("FAIL u1_rereset got %0d/%0d exp 5/3", lat, c1.length); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    c0.cmd_valid = 1'b0; c0.cmd_mode = 2'd0; c0.forward = 2'd0; c0.food_pos = 8'h00; c0.rd_index = 8'h00;
    c1.cmd_valid = 1'b0; c1.cmd_mode = 2'd0; c1.forward = 2'd0; c1.food_pos = 8'h00; c1.rd_index = 8'h00;
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;
    #1;
    test_reset();
    test_step();
    test_eat();
    test_reversal();
    test_read();
    test_self_hit();
    test_wall();
    test_tail_vacate();
    test_lat2_wrap();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
